// File: rtl/spi_cmd_fifo_if.sv
// Handshake bundle between the SPI slave byte strobe, the command FIFO and the DSP engine.
// Optional watermark flag present when SPI_FIFO_WATERMARK_EN is defined.
interface spi_cmd_fifo_if #(
    parameter int unsigned depth      = 32,
    parameter int unsigned data_width = 8
);
    localparam int unsigned cnt_w = $clog2(depth) + 1;

    logic                  flush;
    logic [data_width-1:0] in_byte;
    logic                  in_valid;
    logic [data_width-1:0] out_byte;
    logic                  out_valid;
    logic                  out_ready;
    logic [cnt_w-1:0]      count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
`ifdef SPI_FIFO_WATERMARK_EN
    logic                  almost_full;

    modport master (
        output flush, in_byte, in_valid, out_ready,
        input  out_byte, out_valid, count, empty, full, overflow, almost_full
    );
    modport slave (
        input  flush, in_byte, in_valid, out_ready,
        output out_byte, out_valid, count, empty, full, overflow, almost_full
    );
`else
    modport master (
        output flush, in_byte, in_valid, out_ready,
        input  out_byte, out_valid, count, empty, full, overflow
    );
    modport slave (
        input  flush, in_byte, in_valid, out_ready,
        output out_byte, out_valid, count, empty, full, overflow
    );
`endif
endinterface

// File: rtl/spi_cmd_fifo.sv
// Command byte FIFO between the SPI slave and the DSP engine.
// First-word fall-through head, registered fill level and status flags,
// sticky overflow on dropped writes. Define SPI_FIFO_WATERMARK_EN to add almost_full.
module spi_cmd_fifo #(
    parameter int unsigned depth             = 32,
    parameter int unsigned data_width        = 8,
    parameter int unsigned almost_full_level = 24
) (
    input  logic          clk,
    input  logic          reset,
    spi_cmd_fifo_if.slave bus
);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = ptr_w + 1;

    // Elaboration guard on the parameter set
    if (depth < 4 || (depth & (depth - 1)) != 0 || almost_full_level > depth) begin : g_param_check
        $error("spi_cmd_fifo: illegal depth/almost_full_level");
    end

    logic [data_width-1:0] mem [depth];
    logic [ptr_w-1:0]      rd_ptr;
    logic [ptr_w-1:0]      wr_ptr;
    logic [cnt_w-1:0]      count_q;
    logic [cnt_w-1:0]      count_d;
    logic                  empty_q;
    logic                  full_q;
    logic                  overflow_q;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Handshake decode: a pop frees a slot for a same-cycle push when full
    always_comb begin
        pop  = !empty_q && bus.out_ready;
        push = bus.in_valid && (!full_q || pop);
        drop = bus.in_valid && full_q && !pop;
    end

    // Next fill level; flush wins over any traffic
    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + cnt_w'(1);
        end else if (pop && !push) begin
            count_d = count_q - cnt_w'(1);
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem[wr_ptr] <= bus.in_byte;
        end
    end

    // Pointers, level, status flags and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == cnt_w'(depth));
            if (bus.flush) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_w'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + ptr_w'(1);
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_FIFO_WATERMARK_EN
    logic almost_full_q;

    // Watermark tracks the next-state level so it moves with count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= cnt_w'(almost_full_level));
        end
    end

    assign bus.almost_full = almost_full_q;
`endif

    assign bus.out_byte  = mem[rd_ptr];
    assign bus.out_valid = !empty_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.overflow  = overflow_q;
endmodule
